// File: rtl/sprite_blit_engine_if.sv
// Bus between the game datapath and the sprite blit engine: the command
// fields, the shared ROM address/data pair and the VGA plot outputs.
interface sprite_blit_engine_if #(
  parameter int XW = 8,
  parameter int YW = 7,
  parameter int CW = 3,
  parameter int AW = 15,
  parameter int DW = 8
);
  logic          start;
  logic          abort;
  logic [XW-1:0] x0;
  logic [YW-1:0] y0;
  logic [DW-1:0] w;
  logic [DW-1:0] h;
  logic [AW-1:0] base_addr;
  logic          fill_en;
  logic [CW-1:0] fill_color;
  logic          mirror;
  logic          key_en;
  logic [CW-1:0] key_color;
  logic [AW-1:0] rom_addr;
  logic [CW-1:0] rom_q;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic [CW-1:0] color;
  logic          plot;
  logic          busy;
  logic          done;

  // Game FSM / ROM side: issues commands, returns ROM data
  modport master (
    output start, abort, x0, y0, w, h, base_addr, fill_en, fill_color,
           mirror, key_en, key_color, rom_q,
    input  rom_addr, x, y, color, plot, busy, done
  );

  // Engine side
  modport slave (
    input  start, abort, x0, y0, w, h, base_addr, fill_en, fill_color,
           mirror, key_en, key_color, rom_q,
    output rom_addr, x, y, color, plot, busy, done
  );
endinterface

// File: rtl/sprite_blit_engine.sv
// Programmable rectangle/sprite draw engine: scans a W x H rectangle one
// pixel per clock, fetches colour from ROM (or uses a solid fill), applies
// mirroring, colour-key transparency and screen-edge clipping.
module sprite_blit_engine #(
  parameter int XW       = 8,
  parameter int YW       = 7,
  parameter int CW       = 3,
  parameter int AW       = 15,
  parameter int DW       = 8,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int ROM_LAT  = 1
) (
  input logic                clk,
  input logic                reset,
  sprite_blit_engine_if.slave bus
);
  // Coordinate sums are wide enough to keep the carry out of x0+col / y0+row
  localparam int CXW = ((XW > DW) ? XW : DW) + 1;
  localparam int CYW = ((YW > DW) ? YW : DW) + 1;

  typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

  typedef struct packed {
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [DW-1:0] w;
    logic [DW-1:0] h;
    logic          fill_en;
    logic [CW-1:0] fill_color;
    logic          mirror;
    logic          key_en;
    logic [CW-1:0] key_color;
  } cmd_t;

  state_t                    state_q, state_d;
  cmd_t                      cmd_q, cmd_d;
  logic [DW-1:0]             col_q, col_d, row_q, row_d;
  logic [AW-1:0]             rowbase_q, rowbase_d;
  logic [1:0]                drn_q, drn_d;
  logic [ROM_LAT:1]          vld_q, vld_d, clip_q, clip_d;
  logic [ROM_LAT:1][XW-1:0]  px_q, px_d;
  logic [ROM_LAT:1][YW-1:0]  py_q, py_d;
  logic [XW-1:0]             xh_q, xh_d;
  logic [YW-1:0]             yh_q, yh_d;
  logic [CW-1:0]             ch_q, ch_d;

  logic           kill;
  logic [CXW-1:0] xs;
  logic [CYW-1:0] ys;
  logic [DW-1:0]  acol;
  logic           key_hit, plot_o;
  logic [CW-1:0]  col_o;

  // Pixel issue: coordinates, clip flag and ROM address of the current pixel
  always_comb begin
    kill = bus.abort && (state_q != IDLE);
    xs   = CXW'(cmd_q.x0) + CXW'(col_q);
    ys   = CYW'(cmd_q.y0) + CYW'(row_q);
    acol = cmd_q.mirror ? (cmd_q.w - DW'(1) - col_q) : col_q;
  end
  assign bus.rom_addr = rowbase_q + AW'(acol);

  // Control FSM: command capture, raster scan counters and drain timing
  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    col_d     = col_q;
    row_d     = row_q;
    rowbase_d = rowbase_q;
    drn_d     = drn_q;
    case (state_q)
      IDLE: if (bus.start && !bus.abort) begin
        cmd_d     = '{x0: bus.x0, y0: bus.y0, w: bus.w, h: bus.h,
                      fill_en: bus.fill_en, fill_color: bus.fill_color,
                      mirror: bus.mirror, key_en: bus.key_en,
                      key_color: bus.key_color};
        col_d     = '0;
        row_d     = '0;
        rowbase_d = bus.base_addr;
        drn_d     = '0;
        state_d   = (bus.w == '0 || bus.h == '0) ? DRAIN : SCAN;
      end
      SCAN: begin
        if (col_q == cmd_q.w - DW'(1)) begin
          col_d     = '0;
          row_d     = row_q + DW'(1);
          rowbase_d = rowbase_q + AW'(cmd_q.w);
          if (row_q == cmd_q.h - DW'(1)) state_d = DRAIN;
        end else begin
          col_d = col_q + DW'(1);
        end
      end
      // Wait ROM_LAT cycles so the last issued pixel reaches the output
      DRAIN: begin
        if (drn_q == 2'(ROM_LAT - 1)) state_d = DONE;
        else                          drn_d   = drn_q + 2'd1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (kill) state_d = IDLE;
  end

  // Pixel pipeline: ROM_LAT stages so coordinates line up with rom_q
  always_comb begin
    vld_d     = vld_q;
    clip_d    = clip_q;
    px_d      = px_q;
    py_d      = py_q;
    vld_d[1]  = (state_q == SCAN);
    clip_d[1] = (xs >= CXW'(SCREEN_W)) || (ys >= CYW'(SCREEN_H));
    px_d[1]   = xs[XW-1:0];
    py_d[1]   = ys[YW-1:0];
    for (int k = 2; k <= ROM_LAT; k++) begin
      vld_d[k]  = vld_q[k-1];
      clip_d[k] = clip_q[k-1];
      px_d[k]   = px_q[k-1];
      py_d[k]   = py_q[k-1];
    end
    if (kill) vld_d = '0;
  end

  // Plot decision; x/y/colour hold their last plotted values otherwise
  always_comb begin
    key_hit = cmd_q.key_en && !cmd_q.fill_en && (bus.rom_q == cmd_q.key_color);
    plot_o  = vld_q[ROM_LAT] && !clip_q[ROM_LAT] && !key_hit;
    col_o   = cmd_q.fill_en ? cmd_q.fill_color : bus.rom_q;
    xh_d    = plot_o ? px_q[ROM_LAT] : xh_q;
    yh_d    = plot_o ? py_q[ROM_LAT] : yh_q;
    ch_d    = plot_o ? col_o         : ch_q;
  end

  assign bus.plot  = plot_o;
  assign bus.x     = xh_d;
  assign bus.y     = yh_d;
  assign bus.color = ch_d;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cmd_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      rowbase_q <= '0;
      drn_q     <= '0;
      vld_q     <= '0;
      clip_q    <= '0;
      px_q      <= '0;
      py_q      <= '0;
      xh_q      <= '0;
      yh_q      <= '0;
      ch_q      <= '0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      col_q     <= col_d;
      row_q     <= row_d;
      rowbase_q <= rowbase_d;
      drn_q     <= drn_d;
      vld_q     <= vld_d;
      clip_q    <= clip_d;
      px_q      <= px_d;
      py_q      <= py_d;
      xh_q      <= xh_d;
      yh_q      <= yh_d;
      ch_q      <= ch_d;
    end
  end
endmodule

// File: tb/tb_sprite_blit_engine.sv
// Directed bench for sprite_blit_engine: three engines (ROM_LAT 1..3) share
// one command stream; each has its own ROM delay line and plot logger.
module tb_sprite_blit_engine;
  localparam int XW = 8, YW = 7, CW = 3, AW = 15, DW = 8;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic          start = 0, abort = 0, fill_en = 0, mirror = 0, key_en = 0;
  logic [XW-1:0] x0 = '0;
  logic [YW-1:0] y0 = '0;
  logic [DW-1:0] w = '0, h = '0;
  logic [AW-1:0] base_addr = '0;
  logic [CW-1:0] fill_color = '0, key_color = '0;
  logic [CW-1:0] rom_mem [0:1023];

  int   ecount = 0, s_edge = 0, nchk = 0, nfail = 0;
  logic clr = 0;
  always @(posedge clk) ecount <= ecount + 1;

  for (genvar g = 0; g < 3; g++) begin : gl
    sprite_blit_engine_if #(.XW(XW), .YW(YW), .CW(CW), .AW(AW), .DW(DW)) bif();
    assign bif.start      = start;
    assign bif.abort      = abort;
    assign bif.x0         = x0;
    assign bif.y0         = y0;
    assign bif.w          = w;
    assign bif.h          = h;
    assign bif.base_addr  = base_addr;
    assign bif.fill_en    = fill_en;
    assign bif.fill_color = fill_color;
    assign bif.mirror     = mirror;
    assign bif.key_en     = key_en;
    assign bif.key_color  = key_color;

    logic [CW-1:0] rq1, rq2, rq3;
    always @(posedge clk) begin
      rq1 <= rom_mem[bif.rom_addr[9:0]];
      rq2 <= rq1;
      rq3 <= rq2;
    end
    assign bif.rom_q = (g == 0) ? rq1 : (g == 1) ? rq2 : rq3;

    sprite_blit_engine #(.XW(XW), .YW(YW), .CW(CW), .AW(AW), .DW(DW),
                         .SCREEN_W(160), .SCREEN_H(120), .ROM_LAT(g + 1))
      dut (.clk(clk), .reset(reset), .bus(bif));

    logic [17:0] lg[$];
    int   n_done = 0, done_cyc = -1, first_cyc = -1, fall_cyc = -1;
    logic busy_d = 0;
    always @(posedge clr) begin
      lg.delete();
      n_done = 0; done_cyc = -1; first_cyc = -1; fall_cyc = -1;
    end
    always @(negedge clk) begin
      if (bif.plot) begin
        if (lg.size() == 0) first_cyc = ecount - s_edge + 1;
        lg.push_back({bif.x, bif.y, bif.color});
      end
      if (bif.done) begin
        n_done++;
        done_cyc = ecount - s_edge + 1;
      end
      if (busy_d && !bif.busy && fall_cyc < 0) fall_cyc = ecount - s_edge + 1;
      busy_d = bif.busy;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pk(input int px, input int py, input int pc);
    return {14'd0, 8'(px), 7'(py), 3'(pc)};
  endfunction

  // Issue one start pulse; returns at the negedge inside cycle 1
  task automatic go();
    @(negedge clk);
    clr = 1; #1 clr = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    s_edge = ecount;
  endtask

  task automatic wait_all(input int lim);
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (gl[0].n_done > 0 && gl[1].n_done > 0 && gl[2].n_done > 0) break;
    end
    repeat (3) @(negedge clk);
  endtask

  int ma[6] = '{102, 101, 100, 105, 104, 103};
  int mc[6] = '{1, 4, 7, 0, 3, 6};

  initial begin
    for (int i = 0; i < 1024; i++) rom_mem[i] = 3'(i * 5 + 3);
    rom_mem[200] = 3'd0; rom_mem[201] = 3'd5; rom_mem[202] = 3'd0; rom_mem[203] = 3'd7;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", gl[0].bif.busy, 0);
    chk("rst_plot", gl[0].bif.plot, 0);
    chk("rst_done", gl[0].bif.done, 0);
    chk("rst_xyc", {gl[0].bif.x, gl[0].bif.y, gl[0].bif.color}, 0);
    chk("rst_addr", gl[0].bif.rom_addr, 0);
    reset = 0;
    repeat (2) @(negedge clk);

    // Basic fill, inputs changed after start must not matter
    fill_en = 1; fill_color = 3'd4; x0 = 10; y0 = 20; w = 4; h = 2;
    go();
    chk("fill_busy_c1", gl[0].bif.busy, 1);
    fill_color = 3'd1; x0 = 0;
    wait_all(200);
    chk("fill_ndone", gl[0].n_done, 1);
    chk("fill_count", gl[0].lg.size(), 8);
    chk("fill_first", gl[0].first_cyc, 2);
    chk("fill_done", gl[0].done_cyc, 10);
    chk("fill_busyfall", gl[0].fall_cyc, 11);
    chk("fill_done_l3", gl[2].done_cyc, 12);
    for (int i = 0; i < 8; i++) chk("fill_px", gl[0].lg[i], pk(10 + i % 4, 20 + i / 4, 4));

    // ROM read with mirror, all three latencies
    fill_en = 0; base_addr = 100; w = 3; h = 2; mirror = 1; x0 = 0; y0 = 0;
    go();
    for (int i = 0; i < 6; i++) begin
      chk("mir_addr", gl[0].bif.rom_addr, ma[i]);
      @(negedge clk);
    end
    wait_all(200);
    for (int i = 0; i < 6; i++) begin
      chk("mir_px_l1", gl[0].lg[i], pk(i % 3, i / 3, mc[i]));
      chk("mir_px_l2", gl[1].lg[i], pk(i % 3, i / 3, mc[i]));
      chk("mir_px_l3", gl[2].lg[i], pk(i % 3, i / 3, mc[i]));
    end
    chk("mir_count_l3", gl[2].lg.size(), 6);
    chk("mir_done_l1", gl[0].done_cyc, 8);
    chk("mir_done_l2", gl[1].done_cyc, 9);
    chk("mir_done_l3", gl[2].done_cyc, 10);

    // Colour-key transparency
    mirror = 0; base_addr = 200; w = 4; h = 1; key_en = 1; key_color = 0; x0 = 30; y0 = 40;
    go();
    wait_all(200);
    chk("key_count", gl[0].lg.size(), 2);
    chk("key_px0", gl[0].lg[0], pk(31, 40, 5));
    chk("key_px1", gl[0].lg[1], pk(33, 40, 7));
    chk("key_count_l3", gl[2].lg.size(), 2);
    fill_en = 1; fill_color = 0;
    go();
    wait_all(200);
    chk("keyfill_count", gl[0].lg.size(), 4);
    chk("keyfill_px3", gl[0].lg[3], pk(33, 40, 0));

    // Screen-edge clipping
    key_en = 0; fill_color = 3'd2; x0 = 158; y0 = 118; w = 4; h = 4;
    go();
    wait_all(200);
    chk("clip_count", gl[0].lg.size(), 4);
    chk("clip_px0", gl[0].lg[0], pk(158, 118, 2));
    chk("clip_px1", gl[0].lg[1], pk(159, 118, 2));
    chk("clip_px2", gl[0].lg[2], pk(158, 119, 2));
    chk("clip_px3", gl[0].lg[3], pk(159, 119, 2));
    chk("clip_done_l1", gl[0].done_cyc, 18);
    chk("clip_done_l2", gl[1].done_cyc, 19);
    x0 = 255; y0 = 0; w = 2; h = 1;
    go();
    wait_all(200);
    chk("carry_count", gl[0].lg.size(), 0);
    chk("carry_done", gl[0].done_cyc, 4);

    // Abort, with an ignored start in the middle
    fill_color = 3'd5; x0 = 0; y0 = 0; w = 10; h = 10;
    go();
    repeat (4) @(negedge clk);
    x0 = 50; start = 1;
    @(negedge clk);
    start = 0; x0 = 0;
    repeat (14) @(negedge clk);
    abort = 1;
    @(negedge clk);
    abort = 0;
    chk("abort_plot", gl[0].bif.plot, 0);
    chk("abort_busy", gl[0].bif.busy, 0);
    chk("abort_busy_l3", gl[2].bif.busy, 0);
    repeat (30) @(negedge clk);
    chk("abort_nodone", gl[0].n_done + gl[1].n_done + gl[2].n_done, 0);
    chk("abort_count_l1", gl[0].lg.size(), 19);
    chk("abort_count_l2", gl[1].lg.size(), 18);
    chk("abort_count_l3", gl[2].lg.size(), 17);
    chk("abort_last", gl[0].lg[18], pk(8, 1, 5));
    x0 = 7; y0 = 9; w = 1; h = 1; fill_color = 3'd3;
    go();
    wait_all(200);
    chk("restart_count", gl[0].lg.size(), 1);
    chk("restart_px", gl[0].lg[0], pk(7, 9, 3));
    chk("restart_done", gl[0].done_cyc, 3);

    // Degenerate w=0
    w = 0; h = 5;
    go();
    wait_all(200);
    chk("zero_count", gl[0].lg.size() + gl[1].lg.size() + gl[2].lg.size(), 0);
    chk("zero_done_l1", gl[0].done_cyc, 2);
    chk("zero_done_l2", gl[1].done_cyc, 3);
    chk("zero_done_l3", gl[2].done_cyc, 4);

    // Asynchronous reset mid-draw
    fill_color = 3'd6; x0 = 20; y0 = 3; w = 10; h = 10;
    go();
    repeat (4) @(negedge clk);
    chk("pre_rst_plot", gl[0].bif.plot, 1);
    @(posedge clk);
    #2 reset = 1;
    #1;
    chk("arst_busy", gl[0].bif.busy, 0);
    chk("arst_plot", gl[0].bif.plot, 0);
    chk("arst_xyc", {gl[0].bif.x, gl[0].bif.y, gl[0].bif.color}, 0);
    chk("arst_addr", gl[0].bif.rom_addr, 0);
    chk("arst_busy_l3", gl[2].bif.busy, 0);
    @(negedge clk);
    reset = 0;
    repeat (3) @(negedge clk);
    chk("post_rst_busy", gl[0].bif.busy, 0);
    chk("post_rst_plot", gl[0].bif.plot, 0);

    $display("[TB] %0d tests run, %0d failed", nchk, nfail);
    $finish;
  end
endmodule

// File: doc/sprite_blit_engine.md
Name: sprite_blit_engine

Overview:
Parametrised rectangle/sprite draw engine for the VGA game datapath. It replaces the fixed x/y init registers, x/y counters, screen/sprite address counters and colour select with one programmable engine. Each start command draws one W x H rectangle at (x0, y0) and supports these features:
- ROM-sourced or solid-fill colour
- horizontal mirroring
- colour-key transparency
- screen-edge clipping

It drives the VGA adapter plot interface and one shared ROM address bus, and reports busy/done to the game FSM.

Parameters:
XW, 8, x coordinate width
YW, 7, y coordinate width
CW, 3, colour width
AW, 15, ROM address width
DW, 8, width/height field width
SCREEN_W, 160, visible columns; pixels with x >= SCREEN_W are clipped
SCREEN_H, 120, visible rows; pixels with y >= SCREEN_H are clipped
ROM_LAT, 1, ROM read latency in clocks (1..3)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle command strobe; accepted only when busy=0
abort  in  1  synchronous cancel of the current draw
x0  in  XW  top-left x
y0  in  YW  top-left y
w  in  DW  rectangle width in pixels
h  in  DW  rectangle height in pixels
base_addr  in  AW  ROM address of pixel (0,0)
fill_en  in  1  1 = draw fill_color, ignore ROM
fill_color  in  CW  solid colour
mirror  in  1  1 = read each row right-to-left
key_en  in  1  enable transparency
key_color  in  CW  transparent colour value
rom_addr  out  AW  address to the sprite/screen ROMs
rom_q  in  CW  ROM data, valid ROM_LAT clocks after rom_addr
x  out  XW  plot x
y  out  YW  plot y
color  out  CW  plot colour
plot  out  1  write-enable to the VGA adapter
busy  out  1  command in progress
done  out  1  one-cycle completion pulse

Behaviour:
- Reset, asynchronous: state IDLE; all outputs 0; pipeline valid bits cleared.
- Command capture:
  - start with busy=0 latches all command inputs; later changes to the inputs have no effect.
  - start with busy=1 is ignored; there is no queue.
- States:
  - IDLE -> (start) SCAN.
  - If w=0 or h=0, IDLE -> (start) DRAIN directly, with zero pixels.
  - SCAN -> DRAIN after the pixel at col=W-1, row=H-1 is issued.
  - DRAIN -> DONE when the pipeline is empty.
  - DONE -> IDLE unconditionally.
- Busy: 1 in SCAN, DRAIN and DONE; 0 in IDLE.
- Scan order: row-major, col 0..W-1 within row 0..H-1. One pixel is issued per clock in SCAN, with no stalls.
- Address generation:
  - rom_addr = base + row*W + (mirror ? W-1-col : col), modulo 2^AW.
  - row*W is built incrementally with a row-base register that adds W per row. No multiplier.
  - rom_addr is still driven when fill_en=1; it is harmless.
- Pixel pipeline:
  - The issued x = x0+col and y = y0+row are computed at XW+1 and YW+1 bits. A valid bit and a clip flag are carried with each pixel.
  - The pipeline is ROM_LAT stages deep so that rom_q aligns with its coordinates.
  - color = fill_en ? fill_color : rom_q.
- Plot condition: plot = valid AND not clipped AND NOT(key_en AND NOT fill_en AND rom_q == key_color).
  - Clipped means sum x >= SCREEN_W or y >= SCREEN_H, including carry out.
  - When plot=0, x, y and color hold their last values.
- Timing, with start accepted at cycle 0 (sampled on edge 0):
  - The first address is issued at cycle 1.
  - The first plot-eligible output appears at cycle 1+ROM_LAT.
  - The last pixel outputs at cycle W*H+ROM_LAT.
  - done = 1 at cycle W*H+ROM_LAT+1, and busy falls the following cycle.
  - For w=0 or h=0, done occurs at cycle 1+ROM_LAT with no plot.
- Abort:
  - abort=1 in any busy state returns to IDLE on the next edge and clears the pipeline valid bits.
  - plot is 0 from that edge on, and no done is generated.
  - abort has priority over start in the same cycle.
  - abort in IDLE has no effect.
- Maximum size: w = h = 2^DW-1 is legal. Address arithmetic wraps at 2^AW without error.

Test Plan:
- Basic fill: fill_en=1, fill_color=3'b100, x0=10, y0=20, w=4, h=2, ROM_LAT=1.
  - Exactly 8 plots: (10..13, 20) then (10..13, 21), all colour 4.
  - done at cycle 10; busy=1 during cycles 1..10.
- ROM read with mirror: base=100, w=3, h=2, mirror=1.
  - rom_addr sequence is 102, 101, 100, 105, 104, 103.
  - Each plot colour equals the ROM content at that address, delayed by ROM_LAT.
  - Rerun with ROM_LAT=2 and ROM_LAT=3: same plots, done later by 1 and 2 cycles respectively.
- Transparency: key_en=1, key_color=0, ROM row = {0,5,0,7}, w=4, h=1.
  - plot only at col 1 (colour 5) and col 3 (colour 7).
  - With fill_en=1 and fill_color=0, all 4 pixels plot.
- Clipping: x0=158, y0=118, w=4, h=4.
  - Only (158..159, 118..119) plot, 4 pixels total.
  - done at 16+ROM_LAT+1.
  - x0=255, w=2: no plot, because the carry out counts as clipped.
- Abort and ignored start: start a w=10, h=10 draw; pulse start again at cycle 5 (ignored); assert abort at cycle 20.
  - From the next edge: plot=0, busy=0, and no done.
  - A new start is then accepted normally.
- Degenerate and reset cases:
  - w=0, h=5: no plot, done at cycle 1+ROM_LAT.
  - Asynchronous reset mid-draw: all outputs 0 immediately; after reset is released, state is IDLE.
